// File: rtl/mac_rx_dibit_wr.sv
// RMII receive front end: strips preamble/SFD and writes payload dibits into the rx FIFO.
// Optional per-frame byte counter output enabled by defining MAC_RX_BYTE_CNT_EN.
`timescale 1ns/1ps
module mac_rx_dibit_wr #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  Iclk,
  input  logic                  Irst_n,
  input  logic                  Icrs_dv,
  input  logic [DATA_WIDTH-1:0] Irxd,
  input  logic                  Ifull,
  output logic                  Owr_cs,
  output logic [ADDR_SIZE-1:0]  Owr_addr,
  output logic [DATA_WIDTH-1:0] Owr_data,
  output logic                  Oframe_start,
  output logic                  Oframe_end,
`ifdef MAC_RX_BYTE_CNT_EN
  output logic                  Oframe_err,
  output logic [15:0]           Obyte_cnt
`else
  output logic                  Oframe_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_armed;
  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [1:0]           r_dcnt;
  logic                 r_started;
  logic                 w_wr;
  logic                 w_end;
  logic                 w_err;
  logic                 w_enter_data;
  logic                 w_first;

  // Next-state and per-cycle event decode
  always_comb begin
    w_state_nxt  = r_state;
    w_wr         = 1'b0;
    w_end        = 1'b0;
    w_err        = 1'b0;
    w_enter_data = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_armed stays low after reset until the line has been seen idle once
        if (r_armed && Icrs_dv) begin
          if (Irxd == 2'b01) begin
            w_state_nxt = ST_PREAMBLE;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!Icrs_dv) begin
          w_state_nxt = ST_IDLE;
        end else if (Irxd == 2'b01) begin
          w_state_nxt = ST_PREAMBLE;
        end else if (Irxd == 2'b11) begin
          w_state_nxt  = ST_DATA;
          w_enter_data = 1'b1;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!Icrs_dv) begin
          w_end       = 1'b1;
          w_err       = (r_dcnt != 2'd0);
          w_state_nxt = ST_IDLE;
        end else if (Ifull) begin
          w_state_nxt = ST_DROP;
        end else begin
          w_wr        = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DROP: begin
        if (!Icrs_dv) begin
          w_end       = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_first = w_wr & ~r_started;
  end

  // State, pointer, dibit counter and registered outputs
  always_ff @(posedge Iclk or negedge Irst_n) begin
    if (!Irst_n) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_wr_ptr     <= '0;
      r_dcnt       <= 2'd0;
      r_started    <= 1'b0;
      Owr_cs       <= 1'b0;
      Owr_addr     <= '0;
      Owr_data     <= '0;
      Oframe_start <= 1'b0;
      Oframe_end   <= 1'b0;
      Oframe_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!Icrs_dv) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
      if (w_enter_data) begin
        r_dcnt    <= 2'd0;
        r_started <= 1'b0;
      end else if (w_wr) begin
        r_dcnt    <= r_dcnt + 2'd1;
        r_started <= 1'b1;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end else begin
        r_dcnt    <= r_dcnt;
        r_started <= r_started;
      end
      if (w_wr) begin
        Owr_addr <= r_wr_ptr;
        Owr_data <= Irxd;
      end else begin
        Owr_addr <= Owr_addr;
        Owr_data <= Owr_data;
      end
      Owr_cs       <= w_wr;
      Oframe_start <= w_first;
      Oframe_end   <= w_end;
      Oframe_err   <= w_err;
    end
  end

`ifdef MAC_RX_BYTE_CNT_EN
  // Completed payload bytes of the current frame, saturating
  always_ff @(posedge Iclk or negedge Irst_n) begin
    if (!Irst_n) begin
      Obyte_cnt <= 16'd0;
    end else if (w_first) begin
      Obyte_cnt <= 16'd0;
    end else if (w_wr && (r_dcnt == 2'd3) && (Obyte_cnt != 16'hFFFF)) begin
      Obyte_cnt <= Obyte_cnt + 16'd1;
    end else begin
      Obyte_cnt <= Obyte_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mac_rx_dibit_wr.sv
// Scoreboard bench for mac_rx_dibit_wr: a frame-level model queues expected writes/ends,
// a negedge monitor pops and compares whenever the DUT presents a write or frame end.
`timescale 1ns/1ps
module tb_mac_rx_dibit_wr;

  localparam int AW = 3;

  logic          Iclk = 1'b0;
  logic          Irst_n = 1'b0;
  logic          Icrs_dv = 1'b0;
  logic [1:0]    Irxd = 2'b00;
  logic          Ifull = 1'b0;
  logic          Owr_cs;
  logic [AW-1:0] Owr_addr;
  logic [1:0]    Owr_data;
  logic          Oframe_start;
  logic          Oframe_end;
  logic          Oframe_err;
`ifdef MAC_RX_BYTE_CNT_EN
  logic [15:0]   Obyte_cnt;
`endif

  mac_rx_dibit_wr #(.ADDR_SIZE(AW), .DATA_WIDTH(2)) dut (
    .Iclk(Iclk), .Irst_n(Irst_n), .Icrs_dv(Icrs_dv), .Irxd(Irxd), .Ifull(Ifull),
    .Owr_cs(Owr_cs), .Owr_addr(Owr_addr), .Owr_data(Owr_data),
    .Oframe_start(Oframe_start), .Oframe_end(Oframe_end),
`ifdef MAC_RX_BYTE_CNT_EN
    .Oframe_err(Oframe_err), .Obyte_cnt(Obyte_cnt)
`else
    .Oframe_err(Oframe_err)
`endif
  );

  always #5 Iclk = ~Iclk;

  typedef struct {
    bit       is_end;
    int       addr;
    bit [1:0] data;
    bit       start;
    bit       err;
    int       bcnt;
  } ev_t;

  ev_t      exp_q[$];
  bit [1:0] pl[$];
  int       checks = 0;
  int       errors = 0;
  int       mptr = 0;
  int       mbc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write or frame end must match the head of the scoreboard
  always @(negedge Iclk) begin
    ev_t e;
    if (Irst_n && (Owr_cs || Oframe_end)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got cs=%0d end=%0d addr=%0d expected no event at %0t",
                 Owr_cs, Oframe_end, Owr_addr, $time);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_end) begin
          chk("wr_cs", Owr_cs, 1);
          chk("wr_addr", Owr_addr, e.addr);
          chk("wr_data", Owr_data, e.data);
          chk("frame_start", Oframe_start, e.start);
          chk("end_during_wr", Oframe_end, 0);
        end else begin
          chk("frame_end", Oframe_end, 1);
          chk("frame_err", Oframe_err, e.err);
          chk("cs_during_end", Owr_cs, 0);
`ifdef MAC_RX_BYTE_CNT_EN
          chk("byte_cnt", Obyte_cnt, e.bcnt);
`endif
        end
      end
    end
  end

  task automatic step(input bit crs, input bit [1:0] rxd, input bit full);
    @(posedge Iclk);
    #1;
    Icrs_dv = crs;
    Irxd    = rxd;
    Ifull   = full;
  endtask

  task automatic push_wr(input bit [1:0] d, input bit first);
    ev_t e;
    e.is_end = 1'b0; e.addr = mptr; e.data = d; e.start = first; e.err = 1'b0; e.bcnt = 0;
    exp_q.push_back(e);
    mptr = (mptr + 1) % (1 << AW);
  endtask

  task automatic push_end(input bit err);
    ev_t e;
    e.is_end = 1'b1; e.addr = 0; e.data = 2'b00; e.start = 1'b0; e.err = err; e.bcnt = mbc;
    exp_q.push_back(e);
  endtask

  // Preamble + SFD + payload pl; Ifull rises at payload index full_at
  task automatic frame(input int npre, input int full_at);
    int n;
    int w;
    n = pl.size();
    w = (full_at < n) ? full_at : n;
    for (int i = 0; i < npre; i++) step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i < w) push_wr(pl[i], i == 0);
      step(1'b1, pl[i], i >= full_at);
    end
    if (w > 0) mbc = (w / 4 > 65535) ? 65535 : w / 4;
    push_end((full_at < n) || (w % 4 != 0));
    step(1'b0, 2'($urandom_range(0, 3)), full_at <= n);
    step(1'b0, 2'b00, 1'b0);
  endtask

  task automatic bad_pre(input int npre, input bit [1:0] bad, input int ntail);
    for (int i = 0; i < npre; i++) step(1'b1, 2'b01, 1'b0);
    step(1'b1, bad, 1'b0);
    for (int i = 0; i < ntail; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    push_end(1'b1);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
  endtask

  // Preamble cut short; SFD coincident with carrier loss counts as loss
  task automatic abort_pre(input int npre);
    for (int i = 0; i < npre; i++) step(1'b1, 2'b01, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    step(1'b0, 2'b00, 1'b0);
  endtask

  task automatic rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(2'($urandom_range(0, 3)));
  endtask

  task automatic reset_mid_frame();
    rand_pl(3);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_wr(pl[i], i == 0);
      step(1'b1, pl[i], 1'b0);
    end
    @(posedge Iclk);
    @(negedge Iclk);
    #1;
    Irst_n = 1'b0;
    #1;
    chk("rst_mid_cs", Owr_cs, 0);
    chk("rst_mid_addr", Owr_addr, 0);
    chk("rst_mid_data", Owr_data, 0);
    chk("rst_mid_start", Oframe_start, 0);
    chk("rst_mid_end", Oframe_end, 0);
    chk("rst_mid_err", Oframe_err, 0);
    mptr = 0;
    mbc = 0;
    @(negedge Iclk);
    @(negedge Iclk);
    #1;
    Irst_n = 1'b1;
    // Rest of the old frame, shaped like a valid preamble: must be ignored
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    #1;
    chk("reset_cs", Owr_cs, 0);
    chk("reset_addr", Owr_addr, 0);
    chk("reset_data", Owr_data, 0);
    chk("reset_start", Oframe_start, 0);
    chk("reset_end", Oframe_end, 0);
    chk("reset_err", Oframe_err, 0);
`ifdef MAC_RX_BYTE_CNT_EN
    chk("reset_byte_cnt", Obyte_cnt, 0);
`endif
    @(negedge Iclk);
    @(negedge Iclk);
    Irst_n = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);

    // Good frame, then back-to-back good frame showing the pointer wrap
    pl = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    frame(7, 1000);
    frame(7, 1000);
    rand_pl(4);
    frame(7, 1000);
    rand_pl(6);
    frame(7, 1000);
    rand_pl(8);
    frame(7, 3);
    bad_pre(2, 2'b10, 3);
    bad_pre(0, 2'b11, 2);
    abort_pre(4);
    rand_pl(5);
    frame(3, 5);

    for (int k = 0; k < 40; k++) begin
      int kind;
      int n;
      kind = $urandom_range(0, 5);
      if (kind <= 2 || kind == 5) begin
        n = $urandom_range(1, 12);
        rand_pl(n);
        frame($urandom_range(1, 8), ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : 1000);
      end else if (kind == 3) begin
        bad_pre($urandom_range(0, 4), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10, $urandom_range(0, 4));
      end else begin
        abort_pre($urandom_range(1, 5));
      end
    end

    reset_mid_frame();
    pl = '{2'b11, 2'b00, 2'b10, 2'b01};
    frame(7, 1000);

    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
